pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, handshaked pipeline register that supersedes the fixed per-stage latches (IF/ID, ID/EXE, EXE/MEM, MEM/WB) with one reusable block. It carries a control bundle and a data bundle with valid/ready flow control, stall hold, synchronous flush with control zeroing, and saturating stall/flush counters. It is instantiated between any two adjacent pipeline stages of the MIPS core and driven by the hazard unit.

## Interface
- `DATA_W`, 32: payload width (ALU result, store data, PC, register index packed by the instantiating stage).
- `CTRL_W`, 8: control bundle width (RegWrite, MemWrite, MemRead, MemtoReg, …). Forced to zero on any bubble.
- `CNT_W`, 16: width of each performance counter.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream stage holds a valid instruction.
- `in_ready`  out  1  this register accepts this cycle.
- `in_ctrl`  in  CTRL_W  control bundle from upstream.
- `in_data`  in  DATA_W  data bundle from upstream.
- `flush`  in  1  hazard unit kills the contents of this stage.
- `out_valid`  out  1  downstream sees a valid instruction.
- `out_ready`  in  1  downstream accepts this cycle (0 = stall).
- `out_ctrl`  out  CTRL_W  registered control; all-zero whenever `out_valid`=0.
- `out_data`  out  DATA_W  registered data; don't-care whenever `out_valid`=0.
- `cnt_clr`  in  1  synchronous clear of both counters.
- `stall_cnt`  out  CNT_W  cycles with `out_valid && !out_ready`.
- `flush_cnt`  out  CNT_W  valid entries discarded by `flush`.

## Operation
- Accept: `in_valid && in_ready` at a rising edge.
- Hand-off: `out_valid && out_ready` at a rising edge.
- Main register, no skid: `in_ready = !out_valid || out_ready`, combinational.
  - On accept, load `in_ctrl`/`in_data` and set `out_valid`=1.
  - On hand-off without accept, clear `out_valid` and zero `out_ctrl`. `out_data` holds its value.
  - On stall (`out_valid && !out_ready`), all outputs hold bit-exact.
- Flush has the highest priority:
  - At that edge `out_valid`←0 and `out_ctrl`←0 (plus the skid entry when the skid buffer is enabled).
  - Any simultaneous input is dropped. `in_ready` reads 1 during flush, so upstream never deadlocks.
- `flush_cnt` increments by the number of valid entries discarded (0, 1, or 2 with the skid buffer), saturating.
- `stall_cnt` increments once per stall cycle, saturating at 2^CNT_W−1. It does not wrap.
- `cnt_clr` zeroes both counters. It beats a same-cycle increment.
- Invariant: `out_ctrl`==0 whenever `out_valid`==0. Checked by an assertion.

## Timing
- Reset (async, `rst_n`=0): `out_valid`=0, `out_ctrl`=0, `out_data`=0, skid entry empty, `stall_cnt`=0, `flush_cnt`=0, `in_ready`=1.
  - Reset deassertion is synchronised externally.
  - A reset mid-stall discards all contents immediately, without waiting for a clock edge.
- Latency: accept at edge N → `out_valid`=1 with that payload after edge N.
- Throughput: 1 instruction/cycle with continuous `out_ready`=1.
- Back-to-back stall release: the first cycle with `out_ready`=1 hands off the held entry and accepts the next one at the same edge. No bubble is inserted.

## Configuration
- `PIPE_SKID_EN` defined:
  - Adds one skid entry. `in_ready` becomes registered (`in_ready = !skid_valid`), cutting the combinational `out_ready`→`in_ready` path through the hazard unit.
  - An accept while main is stalled fills the skid entry. The next hand-off moves skid→main.
  - When skid is full, `in_ready`=0.
  - Order is strictly preserved.
  - Same 1-cycle latency when unstalled. Sustains 1/cycle.
- `PIPE_SKID_EN` undefined: single register and combinational `in_ready`, as described under Operation.

## Test plan
- Reset mid-traffic:
  - Stimulus: stream data 0x1..0x4, assert `rst_n`=0 mid-cycle.
  - Response: `out_valid`/`out_ctrl`/counters go to 0 without a clock edge. After release, `in_ready`=1.
- Streaming:
  - Stimulus: `out_ready`=1, inputs 0xA0..0xA7 with `in_ctrl`=0x5A.
  - Response: each appears exactly one cycle later, in order. `stall_cnt`=0.
- Stall hold:
  - Stimulus: hold `out_ready`=0 for 5 cycles with `out_data`=0xDEADBEEF.
  - Response: output bit-stable and `stall_cnt`=5. Upstream sees `in_ready`=0 (no skid), or `in_ready`=0 after one more accept (`PIPE_SKID_EN`).
- Flush:
  - Stimulus: with a valid stalled entry and `in_valid`=1, pulse `flush`.
  - Response: next cycle `out_valid`=0, `out_ctrl`=0x00, input dropped. `flush_cnt`=1 (2 if skid was full).
- Counter saturation and clear:
  - Stimulus: CNT_W=4, stall 20 cycles, then `cnt_clr` together with a stall.
  - Response: `stall_cnt` reaches 15 and holds, then reads 0.
- Random valid/ready/flush, both macro settings:
  - Stimulus: 10k cycles of random handshake and flush traffic.
  - Response: a scoreboard matches order and payload with no loss except flushed entries. The control-zero invariant never fails.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Reusable handshaked pipeline register placed between two adjacent stages of
// the MIPS core. It carries a control bundle and a data bundle and provides:
//   - valid/ready flow control. Stall is out_valid && !out_ready.
//   - synchronous flush from the hazard unit. Flush has the highest priority.
//     It zeroes the control bundle of every held entry and drops any input
//     presented in the same cycle.
//   - saturating stall and flush performance counters with synchronous clear.
//
// Handshake rules:
//   An entry moves across a port at a rising clock edge only when valid and
//   ready are both 1 at that edge. A held entry never changes while it waits.
//   A valid entry never withdraws while it waits. Flush overrides both
//   handshakes: an entry held at a flush edge is discarded, not handed off.
//
// Optional feature (macro PIPE_SKID_EN):
//   When the macro is defined, one skid entry is added behind the main
//   register. in_ready then depends only on registered state, plus flush.
//   This cuts the combinational out_ready -> in_ready path. When the macro is
//   not defined, there is a single register and in_ready is combinational.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   upstream holds a valid instruction
//   in_ready   out  this register accepts this cycle
//   in_ctrl    in   [CTRL_W] control bundle from upstream
//   in_data    in   [DATA_W] data bundle from upstream
//   flush      in   kill the contents of this stage
//   out_valid  out  downstream sees a valid instruction
//   out_ready  in   downstream accepts this cycle (0 = stall)
//   out_ctrl   out  [CTRL_W] registered control, all-zero when out_valid = 0
//   out_data   out  [DATA_W] registered data, holds when out_valid = 0
//   cnt_clr    in   synchronous clear of both counters
//   stall_cnt  out  [CNT_W] number of cycles with out_valid && !out_ready
//   flush_cnt  out  [CNT_W] number of valid entries discarded by flush
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   // Main register
   logic              main_vld_q,  main_vld_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;

   // Performance counters
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic              accept;
   logic              handoff;
   logic              stall;
   logic [1:0]        flush_inc;

   // Saturating add of a small increment. The sum is one bit wider than the
   // counter so that an overflow can be detected and clamped to all-ones.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0]       b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   assign handoff = main_vld_q && out_ready;
   assign stall   = main_vld_q && !out_ready;
   assign accept  = in_valid && in_ready;

`ifdef PIPE_SKID_EN
   logic              skid_vld_q,  skid_vld_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;

   // in_ready comes from a register. Flush is the only combinational term.
   // It keeps upstream moving while the stage is being killed.
   assign in_ready  = !skid_vld_q || flush;
   assign flush_inc = flush ? ({1'b0, main_vld_q} + {1'b0, skid_vld_q}) : 2'd0;

   always_comb begin
      main_vld_d  = main_vld_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_vld_d  = skid_vld_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      if (flush) begin
         main_vld_d  = 1'b0;
         main_ctrl_d = '0;
         skid_vld_d  = 1'b0;
         skid_ctrl_d = '0;
      end else if (handoff) begin
         if (skid_vld_q) begin
            // The older skid entry moves forward. in_ready was 0, so there
            // is no accept in this cycle.
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_vld_d  = 1'b0;
            skid_ctrl_d = '0;
         end else if (accept) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
         end else begin
            main_vld_d  = 1'b0;
            main_ctrl_d = '0;
         end
      end else if (!main_vld_q) begin
         if (accept) begin
            main_vld_d  = 1'b1;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
         end
      end else if (accept) begin
         // Main is stalled, so the new entry parks in the skid slot.
         skid_vld_d  = 1'b1;
         skid_ctrl_d = in_ctrl;
         skid_data_d = in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_vld_q  <= 1'b0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
      end else begin
         skid_vld_q  <= skid_vld_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_data_q <= skid_data_d;
      end
   end
`else
   assign in_ready  = !main_vld_q || out_ready || flush;
   assign flush_inc = (flush && main_vld_q) ? 2'd1 : 2'd0;

   always_comb begin
      main_vld_d  = main_vld_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      if (flush) begin
         main_vld_d  = 1'b0;
         main_ctrl_d = '0;
      end else if (accept) begin
         main_vld_d  = 1'b1;
         main_ctrl_d = in_ctrl;
         main_data_d = in_data;
      end else if (handoff) begin
         // The data field keeps its last value. Only control is cleared.
         main_vld_d  = 1'b0;
         main_ctrl_d = '0;
      end
   end
`endif

   // cnt_clr wins over an increment in the same cycle.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (cnt_clr) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         stall_cnt_d = sat_add(stall_cnt_q, {1'b0, stall});
         flush_cnt_d = sat_add(flush_cnt_q, flush_inc);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_vld_q  <= 1'b0;
         main_ctrl_q <= '0;
         main_data_q <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         main_vld_q  <= main_vld_d;
         main_ctrl_q <= main_ctrl_d;
         main_data_q <= main_data_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign out_valid = main_vld_q;
   assign out_ctrl  = main_ctrl_q;
   assign out_data  = main_data_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

`ifndef SYNTHESIS
   // A bubble must never carry live control signals downstream.
   ctrl_zero_when_idle: assert property (@(posedge clk) disable iff (!rst_n)
      !main_vld_q |-> (main_ctrl_q == '0));
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

   localparam int DATA_W = 32;
   localparam int CTRL_W = 8;
   localparam int CNT_W  = 16;
   localparam int SCNT_W = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic              in_valid = 1'b0;
   logic [CTRL_W-1:0] in_ctrl  = '0;
   logic [DATA_W-1:0] in_data  = '0;
   logic              flush    = 1'b0;
   logic              out_ready = 1'b0;
   logic              cnt_clr  = 1'b0;

   logic              in_ready, out_valid;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic [CNT_W-1:0]  stall_cnt, flush_cnt;

   logic              s_in_ready, s_out_valid;
   logic [CTRL_W-1:0] s_out_ctrl;
   logic [DATA_W-1:0] s_out_data;
   logic [SCNT_W-1:0] s_stall_cnt, s_flush_cnt;

   pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
      .cnt_clr(cnt_clr), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // Narrow-counter instance sharing the same stimulus, used for saturation.
   pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(SCNT_W)) dut_s (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
      .flush(flush),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
      .cnt_clr(cnt_clr), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   // ---------------- scoreboard / reference model ----------------
   // exp_q holds {ctrl, data} of every entry inside the stage, oldest first.
   logic [CTRL_W+DATA_W-1:0] exp_q[$];
   int unsigned m_stall, m_flush, m_stall_s, m_flush_s;
   int unsigned last_data;
   int n_cmp = 0;
   int n_err = 0;
   int n_delivered = 0;

`ifdef PIPE_SKID_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   function automatic int unsigned sat(input int unsigned v, input int unsigned inc, input int w);
      int unsigned mx;
      mx = (1 << w) - 1;
      return (v + inc > mx) ? mx : v + inc;
   endfunction

   // Upstream may push when the stage has room, or when the head leaves this
   // cycle and the stage cannot buffer behind it; flush always reads as ready.
   function automatic logic model_in_ready();
      if (flush) return 1'b1;
      if (DEPTH == 2) return exp_q.size() < 2;
      return exp_q.size() == 0 || out_ready;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
      last_data = 0;
   endtask

   task automatic check_all();
      logic                     busy;
      logic [CTRL_W+DATA_W-1:0] head;
      busy = exp_q.size() > 0;
      head = busy ? exp_q[0] : '0;
      chk("out_valid", 64'(out_valid), 64'(busy));
      chk("out_ctrl", 64'(out_ctrl), busy ? 64'(head[CTRL_W+DATA_W-1:DATA_W]) : 64'd0);
      chk("out_data", 64'(out_data), busy ? 64'(head[DATA_W-1:0]) : 64'(last_data));
      chk("in_ready", 64'(in_ready), 64'(model_in_ready()));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
      chk("s_out_valid", 64'(s_out_valid), 64'(busy));
      chk("s_out_ctrl", 64'(s_out_ctrl), busy ? 64'(head[CTRL_W+DATA_W-1:DATA_W]) : 64'd0);
      chk("s_in_ready", 64'(s_in_ready), 64'(model_in_ready()));
      chk("s_stall_cnt", 64'(s_stall_cnt), 64'(m_stall_s));
      chk("s_flush_cnt", 64'(s_flush_cnt), 64'(m_flush_s));
   endtask

   task automatic model_edge();
      logic        rdy;
      int unsigned st_inc, fl_inc;
      rdy    = model_in_ready();
      st_inc = (exp_q.size() > 0 && !out_ready) ? 1 : 0;
      fl_inc = flush ? exp_q.size() : 0;
      if (cnt_clr) begin
         m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
      end else begin
         m_stall   = sat(m_stall, st_inc, CNT_W);
         m_flush   = sat(m_flush, fl_inc, CNT_W);
         m_stall_s = sat(m_stall_s, st_inc, SCNT_W);
         m_flush_s = sat(m_flush_s, fl_inc, SCNT_W);
      end
      if (flush) begin
         exp_q.delete();
      end else begin
         if (exp_q.size() > 0 && out_ready) begin
            void'(exp_q.pop_front());
            n_delivered++;
         end
         if (in_valid && rdy) begin
            exp_q.push_back({in_ctrl, in_data});
            last_data = in_data;
         end
      end
   endtask

   // One clock: compare at the falling edge, advance the model at the rising
   // edge, return 1 time unit later so new inputs are applied clear of it.
   task automatic cycle();
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                        input logic ordy, input logic fl, input logic clr);
      in_valid = v; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl; cnt_clr = clr;
   endtask

   // ---------------- table vectors ----------------
   typedef struct {
      logic              in_valid;
      logic [CTRL_W-1:0] in_ctrl;
      logic [DATA_W-1:0] in_data;
      logic              out_ready;
      logic              exp_valid;
      logic [CTRL_W-1:0] exp_ctrl;
      logic [DATA_W-1:0] exp_data;
   } vec_t;

   vec_t vecs[9];

   initial begin
      // Streaming A0..A7 with ctrl 5A, then one idle cycle draining the last.
      for (int i = 0; i < 8; i++) begin
         vecs[i].in_valid  = 1'b1;
         vecs[i].in_ctrl   = 8'h5A;
         vecs[i].in_data   = 32'hA0 + 32'(i);
         vecs[i].out_ready = 1'b1;
         vecs[i].exp_valid = 1'b1;
         vecs[i].exp_ctrl  = 8'h5A;
         vecs[i].exp_data  = 32'hA0 + 32'(i);
      end
      vecs[8].in_valid  = 1'b0;
      vecs[8].in_ctrl   = 8'h00;
      vecs[8].in_data   = 32'h0;
      vecs[8].out_ready = 1'b1;
      vecs[8].exp_valid = 1'b0;
      vecs[8].exp_ctrl  = 8'h00;
      vecs[8].exp_data  = 32'hA7;

      // ---- reset ----
      model_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      chk("rst_flush_cnt", 64'(flush_cnt), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ---- table: streaming ----
      for (int i = 0; i < 9; i++) begin
         drive(vecs[i].in_valid, vecs[i].in_ctrl, vecs[i].in_data, vecs[i].out_ready, 1'b0, 1'b0);
         cycle();
         chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
         chk($sformatf("tbl%0d_ctrl", i), 64'(out_ctrl), 64'(vecs[i].exp_ctrl));
         chk($sformatf("tbl%0d_data", i), 64'(out_data), 64'(vecs[i].exp_data));
      end
      chk("stream_stall_cnt", 64'(stall_cnt), 64'd0);

      // ---- stall hold ----
      drive(1'b1, 8'h3C, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
      cycle();
      drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("hold_valid", 64'(out_valid), 64'd1);
         chk("hold_ctrl", 64'(out_ctrl), 64'h3C);
         chk("hold_data", 64'(out_data), 64'hDEADBEEF);
      end
      chk("hold_stall_cnt", 64'(stall_cnt), 64'd5);
`ifdef PIPE_SKID_EN
      chk("hold_in_ready", 64'(in_ready), 64'd1);
      drive(1'b1, 8'h22, 32'h11111111, 1'b0, 1'b0, 1'b0);
      cycle();
      chk("skidfull_in_ready", 64'(in_ready), 64'd0);
      chk("skidfull_data", 64'(out_data), 64'hDEADBEEF);
`else
      chk("hold_in_ready", 64'(in_ready), 64'd0);
`endif

      // ---- flush with stalled entry and simultaneous input ----
      drive(1'b1, 8'h77, 32'h99, 1'b0, 1'b1, 1'b0);
      #1;
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      cycle();
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_out_ctrl", 64'(out_ctrl), 64'd0);
      chk("flush_cnt", 64'(flush_cnt), 64'(DEPTH));
      drive(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);
      cycle();
      chk("flush_dropped", 64'(out_valid), 64'd0);

      // ---- counter saturation and clear ----
      drive(1'b1, 8'h0F, 32'h55, 1'b0, 1'b0, 1'b1);
      cycle();
      drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);
      repeat (20) cycle();
      chk("sat_s_stall_cnt", 64'(s_stall_cnt), 64'd15);
      chk("sat_stall_cnt", 64'(stall_cnt), 64'd20);
      drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
      cycle();
      chk("clr_s_stall_cnt", 64'(s_stall_cnt), 64'd0);
      chk("clr_stall_cnt", 64'(stall_cnt), 64'd0);
      drive(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);
      cycle();

      // ---- reset mid-traffic ----
      drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);
      cycle();
      cycle();   // leaves a stalled-free idle, then stream with a stall
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 8'h81, 32'(i), (i != 3), 1'b0, 1'b0);
         cycle();
      end
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("mrst_out_valid", 64'(out_valid), 64'd0);
      chk("mrst_out_ctrl", 64'(out_ctrl), 64'd0);
      chk("mrst_stall_cnt", 64'(stall_cnt), 64'd0);
      chk("mrst_flush_cnt", 64'(flush_cnt), 64'd0);
      chk("mrst_in_ready", 64'(in_ready), 64'd1);
      drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mrst_rel_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;

      // ---- random traffic ----
      for (int i = 0; i < 10000; i++) begin
         drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom,
               $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
               $urandom_range(0, 63) == 0);
         cycle();
      end
      drive(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);
      repeat (3) cycle();
      chk("drain_empty", 64'(out_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
